// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller in front of a two-port RAM with 2-cycle read latency
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 9,
  parameter int AFULL_THRESH = 496
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  afull,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  v1;
  logic                  v2;
  logic [DATA_WIDTH-1:0] buf_mem [0:3];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [2:0]            buf_cnt;
  logic [2:0]            credits;
  logic                  push;
  logic                  pop;
  logic                  issue;

  // Occupancy decode, push/pop qualification and read-issue credit check
  always_comb begin
    ram_cnt   = wptr - rptr;
    full      = (ram_cnt == DEPTH);
    push      = wr_en & ~full;
    ram_wren  = push & ~Reset;
    ram_waddr = wptr[ADDR_WIDTH-1:0];
    ram_wdata = wr_data;
    ram_raddr = rptr[ADDR_WIDTH-1:0];
    rd_valid  = (buf_cnt != 3'd0);
    rd_data   = buf_mem[head];
    pop       = rd_valid & rd_ready;
    // Words in flight plus words buffered may never exceed the 4 buffer slots
    credits   = {2'b00, v1} + {2'b00, v2} + buf_cnt;
    issue     = (ram_cnt != '0) & (credits < 3'd4);
    afull     = (count >= AFULL_LVL);
  end

  // RAM pointers and the read-latency valid pipeline
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr <= '0;
      rptr <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (issue)
        rptr <= rptr + 1'b1;
      v1 <= issue;
      v2 <= v1;
    end
  end

  // Output buffer pointers and fill level
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      head    <= 2'd0;
      tail    <= 2'd0;
      buf_cnt <= 3'd0;
    end else begin
      if (v2)
        tail <= tail + 2'd1;
      if (pop)
        head <= head + 2'd1;
      buf_cnt <= buf_cnt + {2'b00, v2} - {2'b00, pop};
    end
  end

  // Capture returning RAM data; contents need no reset since buf_cnt gates them
  always_ff @(posedge Clk) begin
    if (v2)
      buf_mem[tail] <= ram_q;
  end

  // Total words held: RAM region, reads in flight and output buffer
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      count <= '0;
    else
      count <= count + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
  end

endmodule
